// File: rtl/add_char_pkg.sv
// Shared types and width helpers for the adder error-characterisation monitors.
package add_char_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic int res_w(input int w);
    return w + 1;
  endfunction

  function automatic int diff_w(input int w);
    return w + 2;
  endfunction

  function automatic int abs_w(input int w);
    return w + 1;
  endfunction

  function automatic int sq_w(input int w);
    return 2 * (w + 1);
  endfunction

  // Bits needed to count the ones in a (w+1)-bit result.
  function automatic int pc_w(input int w);
    return $clog2(w + 2);
  endfunction

  function automatic int sum_abs_w(input int w, input int c);
    return w + 1 + c;
  endfunction

  function automatic int sum_sq_w(input int w, input int c);
    return 2 * (w + 1) + c;
  endfunction

  function automatic int hd_w(input int w, input int c);
    return pc_w(w) + c;
  endfunction

endpackage

// File: rtl/add_err_popcount.sv
// Combinational population count, shared by the adder error monitors.
module add_err_popcount #(
  parameter int W    = 9,
  parameter int PC_W = $clog2(W + 1)
) (
  input  logic [W-1:0]    bits,
  output logic [PC_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + PC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/add8_err_monitor.sv
// Error-statistics monitor for an approximate adder: 2-stage pipeline feeding
// run accumulators. Define ADD8_ERR_MONITOR_MSE_EN to build the squarer and sum_sq.
module add8_err_monitor
  import add_char_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 2 * WIDTH + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [CNT_W-1:0]                 n_samples,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_a,
  input  logic [WIDTH-1:0]                 in_b,
  input  logic [WIDTH:0]                   in_o,
  output logic                             busy,
  output logic                             stat_valid,
  output logic [CNT_W-1:0]                 err_count,
  output logic [WIDTH:0]                   wce,
  output logic [sum_abs_w(WIDTH,CNT_W)-1:0] sum_abs,
  output logic [sum_sq_w(WIDTH,CNT_W)-1:0]  sum_sq,
  output logic [hd_w(WIDTH,CNT_W)-1:0]      hd_sum
);

  localparam int RES_W     = res_w(WIDTH);
  localparam int DIFF_W    = diff_w(WIDTH);
  localparam int ABS_W     = abs_w(WIDTH);
  localparam int PC_W      = pc_w(WIDTH);
  localparam int SUM_ABS_W = sum_abs_w(WIDTH, CNT_W);
  localparam int HD_W      = hd_w(WIDTH, CNT_W);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   n_reg, accepted_reg;
  logic               start_ok, transfer;

  logic               s1_valid_reg, s2_valid_reg;
  logic [RES_W-1:0]   s1_exact_reg, s1_x_reg;
  logic signed [DIFF_W-1:0] s1_diff_reg;
  logic [ABS_W-1:0]   s2_abs_reg;
  logic [PC_W-1:0]    s2_pc_reg;
  logic               s2_ne_reg;

  logic [RES_W-1:0]   exact_next, x_next;
  logic signed [DIFF_W-1:0] diff_next;
  logic [ABS_W-1:0]   abs_next;
  logic [PC_W-1:0]    pc_next;

  always_comb begin
    state_next = state_reg;
    start_ok   = start && (state_reg == IDLE || state_reg == DONE);
    in_ready   = (state_reg == RUN) && (accepted_reg < n_reg);
    transfer   = in_valid && in_ready;
    busy       = (state_reg == RUN) || (state_reg == DRAIN);
    stat_valid = (state_reg == DONE);
    case (state_reg)
      IDLE:  if (start_ok) state_next = RUN;
      RUN: begin
        // An empty run skips the drain; otherwise leave on the final transfer.
        if (n_reg == '0) state_next = DONE;
        else if (transfer && (accepted_reg + CNT_W'(1) == n_reg)) state_next = DRAIN;
      end
      DRAIN: if (!s1_valid_reg && !s2_valid_reg) state_next = DONE;
      DONE:  if (start_ok) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      n_reg        <= '0;
      accepted_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        n_reg        <= n_samples;
        accepted_reg <= '0;
      end else if (transfer) begin
        accepted_reg <= accepted_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    exact_next = RES_W'(in_a) + RES_W'(in_b);
    diff_next  = $signed({1'b0, in_o}) - $signed({1'b0, exact_next});
    x_next     = in_o ^ exact_next;
    abs_next   = ABS_W'(s1_diff_reg[DIFF_W-1] ? -s1_diff_reg : s1_diff_reg);
  end

  add_err_popcount #(.W(RES_W), .PC_W(PC_W)) u_popcount (
    .bits  (s1_x_reg),
    .count (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s1_exact_reg <= '0;
      s1_diff_reg  <= '0;
      s1_x_reg     <= '0;
      s2_abs_reg   <= '0;
      s2_pc_reg    <= '0;
      s2_ne_reg    <= 1'b0;
    end else begin
      s1_valid_reg <= transfer;
      s2_valid_reg <= s1_valid_reg;
      if (transfer) begin
        s1_exact_reg <= exact_next;
        s1_diff_reg  <= diff_next;
        s1_x_reg     <= x_next;
      end
      if (s1_valid_reg) begin
        s2_abs_reg <= abs_next;
        s2_pc_reg  <= pc_next;
        s2_ne_reg  <= (abs_next != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      wce       <= '0;
      sum_abs   <= '0;
      hd_sum    <= '0;
    end else if (start_ok) begin
      err_count <= '0;
      wce       <= '0;
      sum_abs   <= '0;
      hd_sum    <= '0;
    end else if (s2_valid_reg) begin
      err_count <= err_count + CNT_W'(s2_ne_reg);
      if (s2_abs_reg > wce) wce <= s2_abs_reg;
      sum_abs   <= sum_abs + SUM_ABS_W'(s2_abs_reg);
      hd_sum    <= hd_sum + HD_W'(s2_pc_reg);
    end
  end

`ifdef ADD8_ERR_MONITOR_MSE_EN
  localparam int SQ_W     = sq_w(WIDTH);
  localparam int SUM_SQ_W = sum_sq_w(WIDTH, CNT_W);

  logic [SQ_W-1:0]     s2_sq_reg;
  logic [SUM_SQ_W-1:0] sum_sq_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sq_reg  <= '0;
      sum_sq_reg <= '0;
    end else begin
      if (s1_valid_reg) s2_sq_reg <= SQ_W'(abs_next) * SQ_W'(abs_next);
      if (start_ok)          sum_sq_reg <= '0;
      else if (s2_valid_reg) sum_sq_reg <= sum_sq_reg + SUM_SQ_W'(s2_sq_reg);
    end
  end

  assign sum_sq = sum_sq_reg;
`else
  assign sum_sq = '0;
`endif

endmodule

// File: doc/add8_err_monitor.md
Name: add8_err_monitor

Overview:
- Sequential error-characterisation block that consumes the outputs of an 8-bit approximate adder.
- For each input sample {A, B, O} it recomputes the exact sum and accumulates the library quality metrics over a run:
  - error count (EP numerator)
  - worst-case error (WCE)
  - sum of absolute error (MAE numerator)
  - sum of squared error (MSE numerator)
  - summed Hamming distance (HD)
- Sits downstream of any add8_* instance in the characterisation harness.
- The harness drives it with exhaustive or random operand sweeps.

Parameters:
- WIDTH, 8, operand width; result width is WIDTH+1.
- CNT_W, 2*WIDTH+1, width of the sample counter and n_samples; covers an exhaustive sweep of 2^(2*WIDTH) samples.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; clears statistics and begins a run; honoured only in IDLE or DONE.
- n_samples  in  CNT_W  samples to consume in this run; sampled on start.
- in_valid  in  1  sample valid.
- in_ready  out  1  high only in RUN while accepted < n_samples.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_o  in  WIDTH+1  approximate adder result.
- busy  out  1  high in RUN and DRAIN.
- stat_valid  out  1  high in DONE; stats held stable.
- err_count  out  CNT_W  samples with O != A+B.
- wce  out  WIDTH+1  max |O-(A+B)|.
- sum_abs  out  WIDTH+1+CNT_W  sum of |error|.
- sum_sq  out  2*(WIDTH+1)+CNT_W  sum of error^2.
- hd_sum  out  4+CNT_W  sum of popcount(O xor (A+B)).

Behaviour:
- Reset (async assert, sync deassert by harness):
  - State goes to IDLE.
  - All outputs are 0, including in_ready, busy and stat_valid.
  - Pipeline valid bits and all accumulators are cleared.
- FSM states:
  - IDLE -> RUN on start. Same cycle: accumulators cleared, accepted counter = 0, n_samples latched.
    - If the latched n_samples = 0, go to DONE next cycle with all stats = 0.
  - RUN: a transfer occurs when in_valid && in_ready. When the accepted count reaches the latched n, in_ready drops the next cycle and the FSM goes to DRAIN.
  - DRAIN: wait until both pipeline stages are empty -> DONE.
  - DONE: stat_valid = 1; outputs hold until start (-> RUN, cleared) or reset.
- start while in RUN or DRAIN is ignored.
- Pipeline: 2 stages, fully pipelined, one sample per cycle.
  - S1 registers:
    - exact = A+B, zero-extended to WIDTH+1.
    - diff = O - exact, signed, WIDTH+2 bits.
    - x = O xor exact.
  - S2 registers:
    - abs = |diff|, WIDTH+1 bits.
    - sq = abs*abs.
    - pc = popcount(x).
    - ne = (abs != 0).
  - Accumulate on the S2 valid bit: err_count += ne; wce = max(wce, abs); sum_abs += abs; sum_sq += sq; hd_sum += pc.
- Latency: the last accepted sample is reflected in the stats 3 cycles after acceptance. stat_valid rises one cycle later.
- Arithmetic:
  - Accumulator widths are sized so an exhaustive sweep cannot overflow. No saturation logic.
  - Worst case: A=B=2^WIDTH-1, O=0 gives abs = 2^(WIDTH+1)-2.
- in_valid without in_ready: the sample is not consumed. Operand inputs are don't-care when in_valid=0.
- Reset mid-run: the run is aborted, all state is cleared, and no partial stats are presented.

Optional Feature:
- Macro: ADD8_ERR_MONITOR_MSE_EN.
- Defined: the S2 squarer and the sum_sq accumulator are instantiated as described.
- Undefined: no squarer and no sum_sq register; sum_sq is tied to 0. All other behaviour and timing are unchanged.

Decomposition:
- Shared package add_char_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - Width localparam functions: RES_W = WIDTH+1, ABS_W, SQ_W, and accumulator widths.
- One sub-module: add_err_popcount, a combinational WIDTH+1-bit popcount. It is reused by the other err monitors.
- Squarer is an inline multiply.

Test Plan:
- Exact adder model, n=65536 exhaustive sweep with O=A+B -> err_count=0, wce=0, sum_abs=0, sum_sq=0, hd_sum=0; stat_valid rises 4 cycles after the last transfer.
- n=1, A=3, B=4, O=5 -> err_count=1, wce=2, sum_abs=2, sum_sq=4, hd_sum=1.
- n=2: first sample A=255, B=255, O=0, then A=0, B=0, O=0 -> err_count=1, wce=510, sum_abs=510, sum_sq=260100, hd_sum=8.
- n=4 with in_valid toggled randomly, plus start pulsed in RUN -> exactly 4 transfers; in_ready low after the 4th; the second start has no effect.
- n=0 start -> DONE one cycle later with all stats 0; a new start from DONE clears and reruns.
- rst_n asserted in RUN after 3 of 10 samples -> all outputs 0 immediately and state IDLE; a subsequent run gives stats from the new samples only.
